// File: rtl/blinky_array_pkg.sv
// blinky_array_pkg: shared definitions for the blink generator.
//  - mode_e         : channel run mode (continuous / one-shot)
//  - DEFAULT_TICK_HZ: default time-base tick rate
//  - calc_w_ch()    : channel-select width, also used by the register-block driver
package blinky_array_pkg;

  typedef enum logic {
    MODE_CONT    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_e;

  localparam int DEFAULT_TICK_HZ = 1000;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int calc_w_ch(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/blinky_array_tick.sv
// tick_gen: free-running prescaler producing a 1-cycle tick every DIV clocks.
//  clk_i     : system clock
//  rst_i     : synchronous reset, active high (counter cleared)
//  restart_i : reload the prescaler to DIV-1 (channel alignment)
//  tick_o    : registered 1-cycle strobe, first one DIV cycles after reset release
module tick_gen
  import blinky_array_pkg::*;
#(
  parameter int CLK_HZ  = 12_000_000,
  parameter int TICK_HZ = DEFAULT_TICK_HZ
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int W_DIV = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W_DIV-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // The counter reads 0 out of reset and reloads DIV-1 on that cycle, so the
  // strobe is registered off the cnt==1 state; this lands the first tick
  // exactly DIV cycles after release and every DIV cycles after that.
  always_comb begin
    cnt_d  = (cnt_q == '0) ? W_DIV'(DIV - 1) : cnt_q - 1'b1;
    tick_d = (cnt_q == W_DIV'(1));
    if (restart_i) begin
      cnt_d  = W_DIV'(DIV - 1);
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/blinky_array.sv
// blinky_array: N_CH independent LED blink channels sharing one prescaled tick.
// Each channel has a programmable period/on-time (in ticks) and a
// continuous or one-shot mode, written over a valid/ready config port.
//  clk_i, rst_i     : clock, synchronous active-high reset
//  cfg_valid_i      : config write request
//  cfg_ready_o      : registered; high from the first cycle after reset release
//  cfg_ch_i         : target channel (>= N_CH is accepted and discarded)
//  cfg_period_i     : period in ticks, 0 turns the channel off
//  cfg_on_i         : on-time in ticks
//  cfg_oneshot_i    : 1 = run one period then stop
//  led_o, busy_o    : registered per-channel outputs
//  sync_i           : only when BLINKY_ARRAY_SYNC_EN is defined; pulse realigns
//                     all busy channels and restarts the prescaler
module blinky_array
  import blinky_array_pkg::*;
#(
  parameter int CLK_HZ  = 12_000_000,
  parameter int TICK_HZ = DEFAULT_TICK_HZ,
  parameter int N_CH    = 4,
  parameter int W_CNT   = 16,
  localparam int W_CH   = calc_w_ch(N_CH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [W_CH-1:0]  cfg_ch_i,
  input  logic [W_CNT-1:0] cfg_period_i,
  input  logic [W_CNT-1:0] cfg_on_i,
  input  logic             cfg_oneshot_i,
`ifdef BLINKY_ARRAY_SYNC_EN
  input  logic             sync_i,
`endif
  output logic [N_CH-1:0]  led_o,
  output logic [N_CH-1:0]  busy_o
);

  logic cfg_ready_q;
  logic cfg_fire;
  logic tick;
  logic sync_w;

`ifdef BLINKY_ARRAY_SYNC_EN
  assign sync_w = sync_i;
`else
  assign sync_w = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) cfg_ready_q <= 1'b0;
    else       cfg_ready_q <= 1'b1;
  end

  assign cfg_ready_o = cfg_ready_q;
  assign cfg_fire    = cfg_valid_i && cfg_ready_q;

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .restart_i (sync_w),
    .tick_o    (tick)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [W_CNT-1:0] period_q, period_d;
    logic [W_CNT-1:0] on_q, on_d;
    logic [W_CNT-1:0] phase_q, phase_d;
    logic [W_CNT-1:0] phase_nxt;
    mode_e            mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             led_q, led_d;
    logic             wr, wrap;

    // Out-of-range channel numbers never match, so those writes are dropped.
    assign wr        = cfg_fire && (cfg_ch_i == W_CH'(i));
    // Only evaluated while busy, where period != 0, so period-1 never underflows.
    assign wrap      = (phase_q == period_q - W_CNT'(1));
    assign phase_nxt = wrap ? '0 : phase_q + W_CNT'(1);

    // Priority: own config write, then sync, then tick advance.
    always_comb begin
      period_d = period_q;
      on_d     = on_q;
      phase_d  = phase_q;
      mode_d   = mode_q;
      busy_d   = busy_q;
      led_d    = led_q;
      if (wr) begin
        period_d = cfg_period_i;
        on_d     = cfg_on_i;
        mode_d   = mode_e'(cfg_oneshot_i);
        phase_d  = '0;
        busy_d   = (cfg_period_i != '0);
        led_d    = (cfg_period_i != '0) && (cfg_on_i != '0);
      end else if (sync_w && busy_q) begin
        phase_d = '0;
        led_d   = (on_q != '0);
      end else if (tick && busy_q) begin
        if (wrap && mode_q == MODE_ONESHOT) begin
          phase_d = '0;
          busy_d  = 1'b0;
          led_d   = 1'b0;
        end else begin
          phase_d = phase_nxt;
          led_d   = (phase_nxt < on_q);
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        period_q <= '0;
        on_q     <= '0;
        phase_q  <= '0;
        mode_q   <= MODE_CONT;
        busy_q   <= 1'b0;
        led_q    <= 1'b0;
      end else begin
        period_q <= period_d;
        on_q     <= on_d;
        phase_q  <= phase_d;
        mode_q   <= mode_d;
        busy_q   <= busy_d;
        led_q    <= led_d;
      end
    end

    assign led_o[i]  = led_q;
    assign busy_o[i] = busy_q;
  end

endmodule

// File: tb/tb_blinky_array.sv
module tb_blinky_array;
  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int N_CH    = 4;
  localparam int W_CNT   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_ch;
  logic [W_CNT-1:0] cfg_period;
  logic [W_CNT-1:0] cfg_on;
  logic             cfg_oneshot;
  logic [N_CH-1:0]  led;
  logic [N_CH-1:0]  busy;
`ifdef BLINKY_ARRAY_SYNC_EN
  logic             sync;
`endif

  always #5 clk = ~clk;

  blinky_array #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .N_CH   (N_CH),
    .W_CNT  (W_CNT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_ch_i     (cfg_ch),
    .cfg_period_i (cfg_period),
    .cfg_on_i     (cfg_on),
    .cfg_oneshot_i(cfg_oneshot),
`ifdef BLINKY_ARRAY_SYNC_EN
    .sync_i       (sync),
`endif
    .led_o        (led),
    .busy_o       (busy)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: each channel is described by its settings plus the
  // number of ticks k it has run since its last write (or realignment).
  int cur       = 0;   // index of the current cycle since reset release
  int next_tick = DIV;
  int mP[N_CH], mO[N_CH], mK[N_CH];
  bit mOs[N_CH];
  bit mRdy;
  logic [8:0] sb[$];   // {ready, led[3:0], busy[3:0]}

  function automatic bit active(int i);
    return (mP[i] != 0) && !(mOs[i] && mK[i] >= mP[i]);
  endfunction

  function automatic logic [8:0] expect_vec();
    logic [3:0] el, eb;
    el = '0; eb = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (active(i)) begin
        eb[i] = 1'b1;
        el[i] = ((mK[i] % mP[i]) < mO[i]);
      end
    end
    return {mRdy, el, eb};
  endfunction

  always @(posedge clk) begin
    bit tk, wr, sy;
    if (rst) begin
      cur = 0; next_tick = DIV; mRdy = 0;
      for (int i = 0; i < N_CH; i++) begin
        mP[i] = 0; mO[i] = 0; mK[i] = 0; mOs[i] = 0;
      end
    end else begin
      tk = (cur == next_tick);
      if (tk) next_tick += DIV;
      wr = cfg_valid && (cur >= 1);
      sy = 1'b0;
`ifdef BLINKY_ARRAY_SYNC_EN
      sy = sync;
`endif
      if (sy) next_tick = cur + DIV;
      for (int i = 0; i < N_CH; i++) begin
        if (wr && int'(cfg_ch) == i) begin
          mP[i] = int'(cfg_period); mO[i] = int'(cfg_on);
          mOs[i] = cfg_oneshot; mK[i] = 0;
        end else if (sy && active(i)) begin
          mK[i] = 0;
        end else if (tk && active(i)) begin
          mK[i]++;
        end
      end
      cur++;
      mRdy = 1;
    end
    sb.push_back(expect_vec());
  end

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  always @(negedge clk) begin
    logic [8:0] exp_v, act_v;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      act_v = {cfg_ready, led, busy};
      tests++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL outputs t=%0t cyc=%0d {ready,led,busy} got=%b want=%b",
                 $time, cur, act_v, exp_v);
      end
    end
  end

  // Drives one config write in the current cycle (called at a falling edge).
  task automatic cfg_write(input int ch, input int p, input int o, input bit os);
    cfg_valid = 1'b1; cfg_ch = 2'(ch);
    cfg_period = W_CNT'(p); cfg_on = W_CNT'(o); cfg_oneshot = os;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0;
    cfg_period = '0; cfg_on = '0; cfg_oneshot = 1'b0;
`ifdef BLINKY_ARRAY_SYNC_EN
    sync = 1'b0;
`endif
    idle(3);
    rst = 1'b0;
    idle(2);

    // Basic channel shapes.
    cfg_write(0, 4, 1, 0);
    cfg_write(1, 3, 5, 0);
    cfg_write(2, 5, 0, 0);
    cfg_write(3, 2, 1, 1);
    idle(100);

    // Write landing on a tick cycle: ch0 restarts, ch1 keeps advancing.
    cfg_write(1, 4, 2, 0);
    begin
      int guard = 0;
      while (cur != next_tick && guard < 4 * DIV) begin
        @(negedge clk); guard++;
      end
      tests++;
      if (cur != next_tick) begin
        fails++;
        $display("FAIL tick_align cyc=%0d want=%0d", cur, next_tick);
      end
    end
    cfg_write(0, 4, 1, 0);
    idle(60);

    // Randomized writes.
    for (int n = 0; n < 60; n++) begin
      idle($urandom_range(0, 25));
      cfg_write($urandom_range(0, 3), $urandom_range(0, 6),
                $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end
    idle(80);

    // Reset mid-operation with a write pending.
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_period = 8'd3; cfg_on = 8'd1;
    rst = 1'b1;
    idle(2);
    cfg_valid = 1'b0;
    rst = 1'b0;
    idle(3);
    for (int n = 0; n < 15; n++) begin
      idle($urandom_range(0, 20));
      cfg_write($urandom_range(0, 3), $urandom_range(1, 5),
                $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end
    idle(60);

`ifdef BLINKY_ARRAY_SYNC_EN
    // Two channels offset by two ticks, then realigned by sync.
    cfg_write(0, 4, 2, 0);
    idle(2 * DIV - 1);
    cfg_write(1, 4, 2, 0);
    idle(15);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    idle(80);
    // Sync coinciding with a write to ch2.
    sync = 1'b1;
    cfg_write(2, 3, 1, 0);
    sync = 1'b0;
    idle(60);
`endif

    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
